// File: rtl/num_buf_pkg.sv
// Shared constants for the Number Input Buffer responder: register map,
// keyboard codes, STATUS/CTRL bit positions and key classification.
package num_buf_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CUR    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_BS    = 8'h08;
    localparam logic [7:0] KEY_ESC   = 8'h1B;
    localparam logic [7:0] KEY_0     = 8'h30;
    localparam logic [7:0] KEY_9     = 8'h39;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_PARITY    = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_NDIG_LSB  = 8;

    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_OVF   = 1;
    localparam int CTRL_CLR_ENTRY = 2;

    typedef enum logic [2:0] {
        KEY_NONE   = 3'd0,
        KEY_DIGIT  = 3'd1,
        KEY_BACK   = 3'd2,
        KEY_CANCEL = 3'd3,
        KEY_COMMIT = 3'd4
    } key_kind_e;

    function automatic key_kind_e decode_key(input logic valid, input logic [7:0] c);
        key_kind_e k;
        if (!valid) begin
            k = KEY_NONE;
        end else if ((c >= KEY_0) && (c <= KEY_9)) begin
            k = KEY_DIGIT;
        end else if (c == KEY_BS) begin
            k = KEY_BACK;
        end else if (c == KEY_ESC) begin
            k = KEY_CANCEL;
        end else if (c == KEY_ENTER) begin
            k = KEY_COMMIT;
        end else begin
            k = KEY_NONE;
        end
        return k;
    endfunction

endpackage

// File: rtl/num_fifo.sv
// Synchronous FIFO of committed numbers; flush has priority over push/pop,
// and a pop frees a slot for a same-cycle push when full.
module num_fifo
    import num_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok_s, push_ok_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/num_buf_responder.sv
// MMIO responder for the Number Input Buffer: assembles BCD digit entries
// from key strokes, commits them as binary into a FIFO the CPU pops via loads.
module num_buf_responder
    import num_buf_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        key_valid,
    input  logic [7:0]  key_char,
    output logic        not_empty
);

    localparam int BCD_W = 4 * MAX_DIGITS;
    localparam int NDW   = $clog2(MAX_DIGITS + 1);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [NDW-1:0]   ndig_q, ndig_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             rd_s, wr_s, ctrl_wr_s, pop_s;
    logic             flush_s, clr_ovf_s, clr_entry_s;
    logic             commit_s, push_s, ovf_set_s;
    logic [31:0]      bin_s, head_s, status_s;
    logic [CW-1:0]    count_s;
    logic             full_s, empty_s;
    key_kind_e        kind_s;
    logic             unused_ok;

    // Weighted sum of decimal digits; the powers of ten fold to constants
    function automatic logic [31:0] bcd_to_bin(input logic [BCD_W-1:0] b);
        logic [31:0] acc;
        logic [31:0] pw;
        acc = 32'd0;
        pw  = 32'd1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            acc = acc + (32'(b[4*i +: 4]) * pw);
            pw  = pw * 32'd10;
        end
        return acc;
    endfunction

    assign rd_s        = sel & rd;
    assign wr_s        = sel & wr & ~rd;
    assign ctrl_wr_s   = wr_s & (addr[3:2] == REG_CTRL);
    assign flush_s     = ctrl_wr_s & wdata[CTRL_FLUSH];
    assign clr_ovf_s   = ctrl_wr_s & wdata[CTRL_CLR_OVF];
    assign clr_entry_s = ctrl_wr_s & wdata[CTRL_CLR_ENTRY];
    assign pop_s       = rd_s & (addr[3:2] == REG_DATA) & ~empty_s;
    assign kind_s      = decode_key(key_valid, key_char);
    assign commit_s    = (kind_s == KEY_COMMIT) & (ndig_q != {NDW{1'b0}});
    assign bin_s       = bcd_to_bin(bcd_q);
    assign push_s      = commit_s & ~flush_s;
    assign ovf_set_s   = push_s & full_s & ~pop_s;
    assign unused_ok   = ^{addr[1:0], wdata[31:3]};

    num_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (bin_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Entry editing; a CTRL clear-entry overrides any key this cycle
    always_comb begin
        bcd_d  = bcd_q;
        ndig_d = ndig_q;
        if (clr_entry_s) begin
            bcd_d  = {BCD_W{1'b0}};
            ndig_d = {NDW{1'b0}};
        end else begin
            case (kind_s)
                KEY_DIGIT: begin
                    if (ndig_q < NDW'(MAX_DIGITS)) begin
                        bcd_d  = (bcd_q << 4) | BCD_W'(key_char[3:0]);
                        ndig_d = ndig_q + NDW'(1);
                    end else begin
                        bcd_d = bcd_q;
                    end
                end
                KEY_BACK: begin
                    if (ndig_q != {NDW{1'b0}}) begin
                        bcd_d  = bcd_q >> 4;
                        ndig_d = ndig_q - NDW'(1);
                    end else begin
                        bcd_d = bcd_q;
                    end
                end
                KEY_CANCEL, KEY_COMMIT: begin
                    bcd_d  = {BCD_W{1'b0}};
                    ndig_d = {NDW{1'b0}};
                end
                default: begin
                    bcd_d  = bcd_q;
                    ndig_d = ndig_q;
                end
            endcase
        end
    end

    // Sticky overflow; a new overflow beats a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // STATUS image and load data mux
    always_comb begin
        status_s                         = 32'd0;
        status_s[ST_NOT_EMPTY]           = ~empty_s;
        status_s[ST_FULL]                = full_s;
        status_s[ST_OVF]                 = ovf_q;
        status_s[ST_PARITY]              = ~empty_s & head_s[0];
        status_s[ST_COUNT_LSB +: 4]      = 4'(count_s);
        status_s[ST_NDIG_LSB +: 4]       = 4'(ndig_q);
        rdata_d                          = rdata_q;
        if (rd_s) begin
            case (addr[3:2])
                REG_STATUS: rdata_d = status_s;
                REG_DATA:   rdata_d = empty_s ? 32'd0 : head_s;
                REG_CUR:    rdata_d = 32'(bcd_q);
                REG_CTRL:   rdata_d = 32'd0;
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q   <= {BCD_W{1'b0}};
            ndig_q  <= {NDW{1'b0}};
            ovf_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            bcd_q   <= bcd_d;
            ndig_q  <= ndig_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign not_empty = ~empty_s;

endmodule

// File: doc/num_buf_responder.md
# num_buf_responder

MMIO responder for the Number Input Buffer region (0x50000000–0x5FFFFFFF) of the Odd/Even game processor. It assembles decimal digits from decoded keyboard characters into BCD entries of up to MAX_DIGITS digits. On Enter it commits the entry as a binary value into a small FIFO. The CPU polls status and pops committed numbers through load/store accesses steered here by the region select from the address decoder.

## Interface
- MAX_DIGITS, 4: digits per entry (BCD nibbles, ≤ 8)
- DEPTH, 4: committed-number FIFO depth (power of two)
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sel  input  1  region select (address bits [31:28] == 4'h5)
- addr  input  4  byte offset; [3:2] selects register, [1:0] ignored
- rd  input  1  load strobe (valid only with sel)
- wr  input  1  store strobe (valid only with sel)
- wdata  input  32  store data
- rdata  output  32  registered load data
- key_valid  input  1  one-cycle strobe, key_char valid
- key_char  input  8  ASCII: '0'–'9' (0x30–0x39), Enter 0x0D, Backspace 0x08, Esc 0x1B
- not_empty  output  1  FIFO holds ≥1 number (level, for LED/IRQ)

## Operation
- Registers (addr[3:2]):
  - 0 STATUS (RO)
    - [0] not_empty
    - [1] full
    - [2] overflow (sticky)
    - [3] head parity (bit0 of head value; 0 when empty)
    - [7:4] FIFO count
    - [11:8] digits in progress
    - others 0
  - 1 DATA (RO): head value, zero-extended; read with FIFO non-empty pops it; read when empty returns 0, no pop, no flag
  - 2 CUR (RO): in-progress BCD, digit 0 in [3:0], unused nibbles 0
  - 3 CTRL (WO)
    - [0] flush FIFO
    - [1] clear overflow
    - [2] clear entry
    - reads return 0
- Writes to offsets 0–2 are ignored.
- Entry state: bcd (4·MAX_DIGITS bits), ndig (0..MAX_DIGITS).
- Key actions (only when key_valid):
  - Digit, ndig<MAX_DIGITS: bcd ← {bcd<<4 | d}, ndig+1.
  - Digit, ndig==MAX_DIGITS: ignored.
  - Backspace: bcd ← bcd>>4, ndig−1. No effect when ndig==0.
  - Esc: bcd, ndig ← 0.
  - Enter, ndig==0: ignored.
  - Enter, ndig>0: binary = Σ dᵢ·10ⁱ is pushed if not full, otherwise dropped and overflow←1. Entry is cleared in both cases.
  - Other codes: ignored.
- Binary conversion is combinational from bcd (constant multiplies), result width 32 bits.
- Same-cycle events:
  - Commit + DATA pop with FIFO full: pop first, push succeeds, count unchanged, no overflow.
  - Commit + DATA pop otherwise: both occur, count unchanged.
  - CTRL flush + commit: flush wins. Committed number is discarded, entry is still cleared, overflow is not set.
  - CTRL clear entry + digit: clear wins.
  - CTRL clear overflow + new overflow: overflow ends 1.
- rd and wr together with sel: wr ignored, rd serviced.

## Timing
- Reset (rst high at a clk edge) clears FIFO, pointers, count, bcd, ndig and overflow. Outputs rdata=0, not_empty=0. Reset mid-entry loses the entry.
- Load latency is 1 cycle: rdata is registered at the edge where sel&rd are sampled and is valid the following cycle. rdata holds its value until the next load.
- No wait states: every access completes in one cycle, so the pipeline load-use stall covers the latency.
- A pop updates pointers at the same edge that captures rdata. STATUS read the next cycle reflects the pop.
- Key actions and commits take effect at the sampling edge. Commit-to-not_empty latency is 1 cycle.
- FIFO pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Structure
- Shared package num_buf_pkg holds:
  - register offsets (REG_STATUS=0, REG_DATA=1, REG_CUR=2, REG_CTRL=3)
  - key codes (KEY_ENTER, KEY_BS, KEY_ESC, KEY_0, KEY_9)
  - STATUS/CTRL bit positions
- Sub-module num_fifo is a synchronous FIFO with push, pop, flush, count, full and empty, and a registered-pointer array.
- Entry logic, BCD-to-binary conversion and the register file live in the top module.

## Test plan
- Keys '4','2',Enter → STATUS=0x011 (not_empty, count 1, parity 0). DATA read → 42. Following STATUS → 0x000.
- Keys '1','2','3','4','5' with MAX_DIGITS=4 → CUR=0x1234, STATUS[11:8]=4. Backspace → CUR=0x0123. Enter → DATA=123, STATUS[3]=1 (odd).
- Commit five entries 1..5 with DEPTH=4 → count 4, full=1, overflow=1. Pops return 1,2,3,4. Fifth pop returns 0 and count stays 0.
- FIFO full, Enter on "9" in the same cycle as a DATA read → read returns oldest, count stays 4, overflow=0. Last pop yields 9.
- Write CTRL=0x1 in the same cycle as Enter on "7" → count 0, CUR=0, overflow=0. Then Esc mid-entry "56" → CUR=0, ndig=0.
- Assert rst after keys '8','8' and one commit → next cycle STATUS=0, CUR=0, rdata=0, not_empty=0.
